uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmit serializer sitting directly downstream of the TX FIFO in the APB UART.
- Pops bytes from the first-word-fall-through FIFO and frames each as start bit, LSB-first data, optional parity and 1 or 2 stop bits.
- Drives the serial line txd.
- Contains its own bit-period counter, so it needs no external baud tick.

Parameters:
DATA_WIDTH, 8, data bits per frame; must match the FIFO data width.
DIV_WIDTH, 16, width of the bit-period divisor.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
baud_div  input  DIV_WIDTH  bit period = baud_div+1 clk cycles
tx_en  input  1  transmitter enable; new frames start only while high
parity_en  input  1  1 = append parity bit
parity_odd  input  1  1 = odd parity, 0 = even (used only when parity_en=1)
stop2  input  1  1 = two stop bits, 0 = one
fifo_dout  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0 (FWFT)
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  pop strobe to FIFO
txd  output  1  serial output, idle high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, txd=1, busy=0, tx_done=0, bit counter=0, divisor counter=0, shift register=0.
  - fifo_rd_en is gated low while rst_n=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. busy = (state != IDLE).
- Start condition: "take" = tx_en && !fifo_empty, evaluated in IDLE or in the last clk of the last stop bit.
- fifo_rd_en is combinational and high for exactly the take cycle. There is at most one pop per frame and never a pop while fifo_empty=1.
- On take:
  - fifo_dout is latched into the shift register.
  - baud_div, parity_en, parity_odd and stop2 are latched into frame-config registers.
  - The parity bit is computed from the latched data: even = XOR of bits; odd = inverted XOR.
  - Next state is START.
- Line output: txd is registered and changes on the clk edge that enters each bit.
  - Each bit is held for exactly latched_div+1 clk cycles.
  - The divisor counter counts 0..latched_div and restarts at each bit boundary.
- Bit sequence per state:
  - START: txd=0 for one bit.
  - DATA: DATA_WIDTH bits, LSB first, with bit index 0..DATA_WIDTH-1.
  - PARITY: entered only if parity_en was latched.
  - STOP: txd=1 for 1 or 2 bits.
- Frame length = (1 + DATA_WIDTH + P + S) × (latched_div+1) clk, where P is 0 or 1 and S is 1 or 2.
- End of frame:
  - tx_done pulses high for one clk, in the cycle after the last stop bit's final clk.
  - Without take: state returns to IDLE and txd stays 1.
  - With take: state goes directly to START, giving back-to-back frames with no idle gap between the stop and next start bit.
- Boundary conditions:
  - tx_en falling mid-frame: the current frame completes normally; no further pops.
  - baud_div or config change mid-frame: no effect until the next take.
  - baud_div=0: 1 clk per bit.
  - FIFO becoming empty during a frame: irrelevant, since data is already latched.
  - Reset mid-frame: txd returns to 1 immediately; the partial frame is abandoned and not retransmitted; no tx_done is produced.
  - No pop occurs in the cycle of reset deassertion unless tx_en && !fifo_empty holds in that cycle.
- Widths: the bit counter is sized clog2(DATA_WIDTH)+1; the divisor counter is DIV_WIDTH bits and has no overflow for any baud_div value.

Test Plan:
- baud_div=3, 8N1, FIFO holds 0xA5, tx_en=1:
  - One fifo_rd_en pulse.
  - txd = 0,1,0,1,0,0,1,0,1,1, each bit 4 clk, 40 clk total.
  - One tx_done at end; busy high throughout.
- parity_en=1, byte 0xA5 (four ones):
  - parity_odd=0 gives parity bit 0.
  - parity_odd=1 gives parity bit 1.
  - stop2=1 gives 12-bit frame = 48 clk at baud_div=3.
- FIFO holds 0x55 and 0x0F, baud_div=0, 8N1:
  - Two pops, 20 contiguous bits with no idle gap.
  - tx_done twice; busy stays high across the boundary; then IDLE with txd=1.
- tx_en=0 with FIFO non-empty:
  - fifo_rd_en never asserts, txd=1, busy=0.
  - Raise tx_en and transmission starts in the same cycle.
- Reset asserted at DATA bit 3 of 0xA5:
  - txd=1 and busy=0 immediately; no tx_done.
  - After release, the next FIFO word is sent and 0xA5 is not resent.
- baud_div changed 3→7 mid-frame: the current frame keeps 4 clk/bit and the next frame uses 8 clk/bit.

Source files
------------

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
//
// Connection between the TX FIFO (first-word-fall-through) and the UART
// transmit serializer.
//
//   fifo_dout   FIFO head word; valid whenever fifo_empty is low
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  pop strobe from the serializer back to the FIFO
//
// Modports:
//   master - FIFO side: drives the data and empty flag, receives the pop
//   slave  - serializer side: consumes the data and empty flag, drives the pop
// ---------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_rd_en;

    modport master (
        output fifo_dout,
        output fifo_empty,
        input  fifo_rd_en
    );

    modport slave (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_rd_en
    );

endinterface : uart_tx_if

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//
// UART transmit serializer fed directly by a first-word-fall-through TX FIFO.
// Each popped word is framed as: start bit (0), DATA_WIDTH data bits LSB
// first, an optional parity bit, then one or two stop bits (1). The bit
// period is generated internally from baud_div, so no external baud tick is
// needed.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   baud_div    bit period = baud_div + 1 clk cycles
//   tx_en       transmitter enable; new frames start only while high
//   parity_en   1 = append a parity bit
//   parity_odd  1 = odd parity, 0 = even (only when parity_en = 1)
//   stop2       1 = two stop bits, 0 = one
//   fifo        FIFO handshake (uart_tx_if.slave): fifo_dout, fifo_empty
//               in, fifo_rd_en out (combinational pop strobe)
//   txd         registered serial output, idle high
//   busy        a frame is in progress
//   tx_done     one-cycle pulse after the last stop bit of each frame
//
// A frame starts on a "take": tx_en high and the FIFO non-empty, looked at
// while idle or during the final clk of the last stop bit. The take cycle
// pops the FIFO and latches the data word together with the whole frame
// configuration, so later changes to baud_div, parity or stop settings (or
// the FIFO draining) cannot disturb a frame already under way. A take in the
// last stop clk chains straight into the next start bit with no idle gap.
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 tx_en,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    uart_tx_if.slave             fifo,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    // Bit counter indexes data bits 0..DATA_WIDTH-1 and, in STOP, the stop
    // bit number; one spare bit keeps DATA_WIDTH-1 representable for any
    // DATA_WIDTH.
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] SECOND_STOP   = BIT_CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state_q, state_d;

    // Frame configuration captured at take time.
    logic [DIV_WIDTH-1:0]  div_q;
    logic                  par_en_q;
    logic                  stop2_q;

    // Per-frame datapath.
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  parity_q;
    logic [DIV_WIDTH-1:0]  div_cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic                  txd_q,     txd_d;
    logic                  tx_done_q, tx_done_d;

    logic bit_end;    // final clk of the current bit
    logic last_stop;  // final clk of the frame's last stop bit
    logic take;       // start a new frame at the coming edge
    logic bit_adv;    // the coming edge enters a new bit

    // The divisor counter runs 0..div_q, so it never needs to exceed
    // DIV_WIDTH bits whatever baud_div was latched.
    assign bit_end   = (div_cnt_q == div_q);
    assign last_stop = (state_q == STOP) && bit_end &&
                       (!stop2_q || (bit_cnt_q == SECOND_STOP));
    assign take      = tx_en && !fifo.fifo_empty &&
                       ((state_q == IDLE) || last_stop);
    assign bit_adv   = take || ((state_q != IDLE) && bit_end);

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers sample pre-edge values and simulation matches the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the hold-current-state default ahead of the case means every
    // path assigns state_d, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (take) state_d = START;
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end && (bit_cnt_q == LAST_DATA_BIT)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (last_stop) state_d = take ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs
    // -----------------------------------------------------------------------
    // txd is registered, so the value chosen here is the level of the bit
    // being entered at the coming edge. Data bits always come from bit 0 of
    // the shift register, which shifts right as each data bit is entered.
    always_comb begin
        // The pop is held off while reset is asserted even though the
        // FSM state alone would already be IDLE.
        fifo.fifo_rd_en = take && rst_n;
        busy            = (state_q != IDLE);
        tx_done_d       = last_stop;
        txd_d           = txd_q;
        if (bit_adv) begin
            case (state_d)
                START:   txd_d = 1'b0;
                DATA:    txd_d = shift_q[0];
                PARITY:  txd_d = parity_q;
                default: txd_d = 1'b1;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    // NOTE: the shift register and config registers are reset along with
    // the control state; they are few flops and a known value after reset
    // keeps the design free of X propagation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_q     <= 1'b1;
            tx_done_q <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            txd_q     <= txd_d;
            tx_done_q <= tx_done_d;

            if (take) begin
                shift_q  <= fifo.fifo_dout;
                parity_q <= (^fifo.fifo_dout) ^ parity_odd;
                div_q    <= baud_div;
                par_en_q <= parity_en;
                stop2_q  <= stop2;
            end else if (bit_adv && (state_d == DATA)) begin
                shift_q  <= shift_q >> 1;
            end

            // Restart the period at every bit boundary; sit at zero when idle.
            if (bit_adv) begin
                div_cnt_q <= '0;
            end else if (state_q != IDLE) begin
                div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
            end

            // Count bits within DATA and within STOP; any state change
            // (including a chained take out of STOP) starts again from zero.
            if (bit_adv) begin
                if ((state_d == state_q) &&
                    ((state_q == DATA) || (state_q == STOP))) begin
                    bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                end else begin
                    bit_cnt_q <= '0;
                end
            end
        end
    end

    assign txd     = txd_q;
    assign tx_done = tx_done_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//
// Self-checking bench for uart_tx. A queue models the FWFT FIFO. Each byte
// the bench expects on the line is pushed, as a bit-level frame, into a
// scoreboard queue; a monitor pops an entry whenever a start bit appears and
// checks every clk of the frame, the busy flag and the tx_done pulse. A
// table of vectors covers framing options; hand-written sequences cover
// back-to-back frames, enable gating, reset mid-frame and a baud change
// mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int DW = 8;
    localparam int VW = 16;

    typedef struct {
        logic [11:0] bits;   // line levels in transmit order, one per bit
        int          nbits;
        int          div;
    } frame_t;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        bit          par_en;
        bit          par_odd;
        bit          stop2;
        bit          exp_par;
        int          exp_clks;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] baud_div = '0;
    logic          tx_en = 1'b0;
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          stop2 = 1'b0;
    logic          txd;
    logic          busy;
    logic          tx_done;

    uart_tx_if #(.DATA_WIDTH(DW)) ifc ();

    uart_tx #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (VW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .tx_en      (tx_en),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .fifo       (ifc),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    logic [7:0]  fifo_q[$];
    frame_t      sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pop_cnt = 0;
    int          bad_pop = 0;
    int          frames_done = 0;
    int          aborted_cnt = 0;
    logic [11:0] mon_bits = '0;

    task automatic check(input bit ok, input string name,
                         input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void refresh_fifo();
        ifc.fifo_empty = (fifo_q.size() == 0);
        ifc.fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endfunction

    function automatic frame_t build(input logic [7:0] d, input int div,
                                     input bit pe, input bit po, input bit s2);
        frame_t f;
        int     n;
        f.bits    = '1;
        f.div     = div;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
        n = 9;
        if (pe) begin
            f.bits[n] = (^d) ^ po;
            n++;
        end
        n += s2 ? 2 : 1;
        f.nbits = n;
        return f;
    endfunction

    task automatic push_fifo(input logic [7:0] d);
        fifo_q.push_back(d);
        refresh_fifo();
    endtask

    task automatic expect_frame(input logic [7:0] d, input int div,
                                input bit pe, input bit po, input bit s2);
        sb_q.push_back(build(d, div, pe, po, s2));
    endtask

    // Waits up to limit falling edges for fifo_rd_en (on_done=0) or tx_done
    // (on_done=1); returns the edge count, or -1 on timeout.
    task automatic wait_for(input bit on_done, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (on_done ? (tx_done === 1'b1) : (ifc.fifo_rd_en === 1'b1)) begin
                cycles = i;
                break;
            end
        end
        #1;
    endtask

    // FIFO model: a pop seen before an edge takes effect just after it.
    initial begin : fifo_model
        bit p;
        forever begin
            @(negedge clk);
            p = ifc.fifo_rd_en;
            if (p && ifc.fifo_empty) bad_pop++;
            @(posedge clk);
            #1;
            if (p) begin
                pop_cnt++;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                refresh_fifo();
            end
        end
    end

    // Line monitor / scoreboard consumer.
    initial begin : monitor
        frame_t f;
        bit     pending;
        bit     abort;
        bit     bit_ok;
        logic   got;
        forever begin
            @(negedge clk);
            if (rst_n && txd === 1'b0) begin
                pending = 1'b1;
                while (pending) begin
                    pending = 1'b0;
                    check(sb_q.size() > 0, "sb_has_entry", sb_q.size(), 1);
                    if (sb_q.size() > 0) begin
                        f     = sb_q.pop_front();
                        abort = 1'b0;
                        for (int b = 0; b < f.nbits && !abort; b++) begin
                            bit_ok = 1'b1;
                            got    = f.bits[b];
                            for (int k = 0; k <= f.div; k++) begin
                                if (b > 0 || k > 0) @(negedge clk);
                                if (!rst_n) begin
                                    abort = 1'b1;
                                    break;
                                end
                                if (k == 0) mon_bits[b] = txd;
                                if (txd !== f.bits[b] || busy !== 1'b1 ||
                                    ((b + k) > 0 && tx_done !== 1'b0)) begin
                                    if (bit_ok) got = txd;
                                    bit_ok = 1'b0;
                                end
                            end
                            if (!abort) check(bit_ok, $sformatf("frame_bit%0d", b), got, f.bits[b]);
                        end
                        if (abort) begin
                            aborted_cnt++;
                        end else begin
                            @(negedge clk);
                            check(tx_done === 1'b1, "tx_done_pulse", tx_done, 1);
                            frames_done++;
                            pending = rst_n && (txd === 1'b0);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t vecs[7];
        int   c;
        int   p0;
        int   f0;
        int   a0;
        int   cnt;
        bit   ok;
        bit   done_s;
        bit   txd_s;

        //         data   div   pe po s2 par clks
        vecs[0] = '{8'hA5, 16'd3, 0, 0, 0, 0, 40};
        vecs[1] = '{8'hA5, 16'd3, 1, 0, 0, 0, 44};
        vecs[2] = '{8'hA5, 16'd3, 1, 1, 0, 1, 44};
        vecs[3] = '{8'hA5, 16'd3, 1, 0, 1, 0, 48};
        vecs[4] = '{8'h3C, 16'd0, 1, 1, 1, 1, 12};
        vecs[5] = '{8'h01, 16'd1, 1, 0, 0, 1, 22};
        vecs[6] = '{8'hFF, 16'd2, 0, 0, 1, 0, 33};

        // Reset state, with a word already waiting and tx_en high.
        refresh_fifo();
        baud_div = 16'd3;
        tx_en    = 1'b1;
        push_fifo(8'hC3);
        expect_frame(8'hC3, 3, 0, 0, 0);
        repeat (3) @(negedge clk);
        check(ifc.fifo_rd_en === 1'b0, "rst_rd_en", ifc.fifo_rd_en, 0);
        check(txd === 1'b1, "rst_txd", txd, 1);
        check(busy === 1'b0, "rst_busy", busy, 0);
        check(tx_done === 1'b0, "rst_tx_done", tx_done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_for(1'b0, 5, c);
        check(c == 1, "release_take", c, 1);
        wait_for(1'b1, 200, c);
        check(c == 41, "release_frame_len", c, 41);
        tx_en = 1'b0;

        // Table of framing options.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            baud_div   = vecs[i].div;
            parity_en  = vecs[i].par_en;
            parity_odd = vecs[i].par_odd;
            stop2      = vecs[i].stop2;
            p0         = pop_cnt;
            push_fifo(vecs[i].data);
            expect_frame(vecs[i].data, int'(vecs[i].div), vecs[i].par_en,
                         vecs[i].par_odd, vecs[i].stop2);
            tx_en = 1'b1;
            wait_for(1'b0, 10, c);
            check(c == 1, $sformatf("v%0d_take", i), c, 1);
            @(posedge clk);
            #1 tx_en = 1'b0;
            wait_for(1'b1, 2000, c);
            check(c - 1 == vecs[i].exp_clks, $sformatf("v%0d_frame_clks", i), c - 1, vecs[i].exp_clks);
            if (vecs[i].par_en)
                check(mon_bits[9] === vecs[i].exp_par, $sformatf("v%0d_parity", i), mon_bits[9], vecs[i].exp_par);
            check(pop_cnt - p0 == 1, $sformatf("v%0d_pops", i), pop_cnt - p0, 1);
            check(busy === 1'b0 && txd === 1'b1, $sformatf("v%0d_idle", i), {busy, txd}, 1);
        end

        // Back-to-back frames at one clk per bit.
        @(posedge clk);
        #1;
        baud_div  = 16'd0;
        parity_en = 1'b0;
        stop2     = 1'b0;
        p0        = pop_cnt;
        f0        = frames_done;
        push_fifo(8'h55);
        push_fifo(8'h0F);
        expect_frame(8'h55, 0, 0, 0, 0);
        expect_frame(8'h0F, 0, 0, 0, 0);
        tx_en = 1'b1;
        wait_for(1'b0, 10, c);
        check(c == 1, "b2b_take", c, 1);
        cnt    = 0;
        done_s = 1'b0;
        txd_s  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                cnt++;
            end else begin
                done_s = tx_done;
                txd_s  = txd;
                break;
            end
        end
        #1;
        check(cnt == 20, "b2b_busy_clks", cnt, 20);
        check(done_s === 1'b1, "b2b_final_done", done_s, 1);
        check(txd_s === 1'b1, "b2b_idle_txd", txd_s, 1);
        check(frames_done - f0 == 2, "b2b_frames", frames_done - f0, 2);
        check(pop_cnt - p0 == 2, "b2b_pops", pop_cnt - p0, 2);
        tx_en = 1'b0;

        // tx_en low holds off a non-empty FIFO; raising it takes at once.
        @(posedge clk);
        #1;
        baud_div = 16'd1;
        p0       = pop_cnt;
        push_fifo(8'h96);
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ifc.fifo_rd_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        check(ok, "hold_off_quiet", ok, 1);
        @(posedge clk);
        #1;
        expect_frame(8'h96, 1, 0, 0, 0);
        tx_en = 1'b1;
        #1 check(ifc.fifo_rd_en === 1'b1, "same_cycle_take", ifc.fifo_rd_en, 1);
        @(posedge clk);
        #1 tx_en = 1'b0;
        push_fifo(8'h11);
        wait_for(1'b1, 200, c);
        check(c == 21, "hold_frame_len", c, 21);
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ifc.fifo_rd_en !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check(ok, "no_pop_after_disable", ok, 1);
        check(pop_cnt - p0 == 1, "hold_pops", pop_cnt - p0, 1);
        @(posedge clk);
        #1;
        expect_frame(8'h11, 1, 0, 0, 0);
        tx_en = 1'b1;
        wait_for(1'b1, 200, c);
        check(c == 22, "resume_frame_len", c, 22);
        tx_en = 1'b0;

        // Reset in DATA bit 3 of 0xA5; the next word follows, 0xA5 is lost.
        @(posedge clk);
        #1;
        baud_div = 16'd3;
        p0       = pop_cnt;
        f0       = frames_done;
        a0       = aborted_cnt;
        push_fifo(8'hA5);
        push_fifo(8'h3C);
        expect_frame(8'hA5, 3, 0, 0, 0);
        expect_frame(8'h3C, 3, 0, 0, 0);
        tx_en = 1'b1;
        wait_for(1'b0, 10, c);
        check(c == 1, "rst_test_take", c, 1);
        repeat (17) @(negedge clk);
        check(txd === 1'b0 && busy === 1'b1, "at_data_bit3", {busy, txd}, 2);
        #1 rst_n = 1'b0;
        #1;
        check(txd === 1'b1, "midrst_txd", txd, 1);
        check(busy === 1'b0, "midrst_busy", busy, 0);
        check(tx_done === 1'b0, "midrst_tx_done", tx_done, 0);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ifc.fifo_rd_en !== 1'b0 || tx_done !== 1'b0) ok = 1'b0;
        end
        check(ok, "in_reset_quiet", ok, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_for(1'b0, 5, c);
        check(c == 1, "post_rst_take", c, 1);
        wait_for(1'b1, 200, c);
        check(c == 41, "post_rst_frame_len", c, 41);
        check(frames_done - f0 == 1, "rst_frames", frames_done - f0, 1);
        check(aborted_cnt - a0 == 1, "rst_aborted", aborted_cnt - a0, 1);
        check(pop_cnt - p0 == 2, "rst_pops", pop_cnt - p0, 2);
        tx_en = 1'b0;

        // baud_div 3 -> 7 during the first of two frames.
        @(posedge clk);
        #1;
        p0 = pop_cnt;
        push_fifo(8'hA5);
        push_fifo(8'h5A);
        expect_frame(8'hA5, 3, 0, 0, 0);
        expect_frame(8'h5A, 7, 0, 0, 0);
        tx_en = 1'b1;
        wait_for(1'b0, 10, c);
        check(c == 1, "bc_take", c, 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 baud_div = 16'd7;
        wait_for(1'b1, 200, c);
        check(c == 31, "bc_first_done", c, 31);
        wait_for(1'b1, 400, c);
        check(c == 80, "bc_second_len", c, 80);
        check(pop_cnt - p0 == 2, "bc_pops", pop_cnt - p0, 2);
        tx_en = 1'b0;

        repeat (5) @(negedge clk);
        check(bad_pop == 0, "pop_while_empty", bad_pop, 0);
        check(sb_q.size() == 0, "sb_drained", sb_q.size(), 0);
        check(txd === 1'b1 && busy === 1'b0, "final_idle", {busy, txd}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx
